// File: rtl/write_inc.sv
// Write-side pointer, synchronized read pointer and full/overflow flags for an async FIFO.
// Optional almost_full output is enabled by defining WRITE_INC_ALMOST_FULL_EN.
module write_inc #(
    parameter int ADDRSIZE  = 4,
    parameter int AF_THRESH = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signal_write,
    input  logic [ADDRSIZE:0]   graycode_rptr,
    output logic                full,
    output logic                write_en,
    output logic [ADDRSIZE-1:0] write_address,
    output logic [ADDRSIZE:0]   graycode_wptr,
`ifdef WRITE_INC_ALMOST_FULL_EN
    output logic                almost_full,
`endif
    output logic                overflow
);

    function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
        return (b >> 1) ^ b;
    endfunction

    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wgray_q, wgray_d;
    logic [ADDRSIZE:0] rq1_q, rq2_q;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;
    logic              inc_s;

`ifdef WRITE_INC_ALMOST_FULL_EN
    localparam logic [ADDRSIZE:0] AF_THRESH_W = AF_THRESH[ADDRSIZE:0];

    // Prefix XOR from the MSB down recovers the binary read pointer.
    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic              af_q, af_d;
    logic [ADDRSIZE:0] occ_s;
`else
    localparam int af_thresh_unused = AF_THRESH;
`endif

    // Next-state for pointer, full and overflow.
    always_comb begin
        inc_s      = signal_write & ~full_q;
        wbin_d     = wbin_q + {{ADDRSIZE{1'b0}}, inc_s};
        wgray_d    = bin2gray(wbin_d);
        // Full when the next write pointer laps the synchronized read pointer.
        full_d     = (wgray_d == {~rq2_q[ADDRSIZE:ADDRSIZE-1], rq2_q[ADDRSIZE-2:0]});
        overflow_d = overflow_q | (signal_write & full_q);
`ifdef WRITE_INC_ALMOST_FULL_EN
        occ_s      = wbin_d - gray2bin(rq2_q);
        af_d       = (occ_s >= AF_THRESH_W);
`endif
    end

    // State registers, including the 2-flop read-pointer synchronizer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbin_q     <= {(ADDRSIZE+1){1'b0}};
            wgray_q    <= {(ADDRSIZE+1){1'b0}};
            rq1_q      <= {(ADDRSIZE+1){1'b0}};
            rq2_q      <= {(ADDRSIZE+1){1'b0}};
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef WRITE_INC_ALMOST_FULL_EN
            af_q       <= 1'b0;
`endif
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            rq1_q      <= graycode_rptr;
            rq2_q      <= rq1_q;
            full_q     <= full_d;
            overflow_q <= overflow_d;
`ifdef WRITE_INC_ALMOST_FULL_EN
            af_q       <= af_d;
`endif
        end
    end

    // The strobe is also held off while reset is asserted so the RAM is untouched.
    assign write_en      = inc_s & rst;
    assign full          = full_q;
    assign write_address = wbin_q[ADDRSIZE-1:0];
    assign graycode_wptr = wgray_q;
    assign overflow      = overflow_q;
`ifdef WRITE_INC_ALMOST_FULL_EN
    assign almost_full   = af_q;
`endif

endmodule

// File: tb/tb_write_inc.sv
// Scoreboard bench for write_inc: an occupancy-based reference model pushes expected
// post-edge outputs, which are popped and compared one time unit after each clock edge.
module tb_write_inc;

    logic       clk = 1'b0;
    logic       rst;
    logic       signal_write;
    logic [4:0] graycode_rptr;
    logic       full;
    logic       write_en;
    logic [3:0] write_address;
    logic [4:0] graycode_wptr;
    logic       overflow;
`ifdef WRITE_INC_ALMOST_FULL_EN
    logic       almost_full;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0] gptr;
        logic [3:0] addr;
        logic       full;
        logic       ovf;
        logic       af;
    } exp_t;

    exp_t sb_q[$];

    logic [4:0] m_wbin, m_rq1, m_rq2;
    logic       m_full, m_ovf, m_af;

    write_inc dut (
        .clk           (clk),
        .rst           (rst),
        .signal_write  (signal_write),
        .graycode_rptr (graycode_rptr),
        .full          (full),
        .write_en      (write_en),
        .write_address (write_address),
        .graycode_wptr (graycode_wptr),
`ifdef WRITE_INC_ALMOST_FULL_EN
        .almost_full   (almost_full),
`endif
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic model_reset();
        m_wbin = 5'd0; m_rq1 = 5'd0; m_rq2 = 5'd0;
        m_full = 1'b0; m_ovf = 1'b0; m_af = 1'b0;
        sb_q.delete();
    endtask

    // One clock: drive inputs, check write_en, push expectation, pop after the edge.
    task automatic cycle(input logic sw, input logic [4:0] rptr);
        exp_t e, a;
        logic [4:0] nb, occ;
        signal_write  = sw;
        graycode_rptr = rptr;
        #1;
        checks++;
        if (write_en !== (sw & ~m_full)) begin
            failures++;
            $display("FAIL write_en: got %b expected %b", write_en, sw & ~m_full);
        end
        nb     = m_wbin + ((sw && !m_full) ? 5'd1 : 5'd0);
        occ    = nb - g2b(m_rq2);
        m_ovf  = m_ovf | (sw & m_full);
        m_full = (occ == 5'd16);
        m_af   = (occ >= 5'd12);
        m_rq2  = m_rq1;
        m_rq1  = rptr;
        m_wbin = nb;
        e = '{gptr: b2g(nb), addr: nb[3:0], full: m_full, ovf: m_ovf, af: m_af};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        a = sb_q.pop_front();
        checks++;
        if (graycode_wptr !== a.gptr) begin
            failures++;
            $display("FAIL sb_gptr: got %b expected %b", graycode_wptr, a.gptr);
        end
        checks++;
        if (write_address !== a.addr) begin
            failures++;
            $display("FAIL sb_addr: got %0d expected %0d", write_address, a.addr);
        end
        checks++;
        if (full !== a.full) begin
            failures++;
            $display("FAIL sb_full: got %b expected %b", full, a.full);
        end
        checks++;
        if (overflow !== a.ovf) begin
            failures++;
            $display("FAIL sb_overflow: got %b expected %b", overflow, a.ovf);
        end
`ifdef WRITE_INC_ALMOST_FULL_EN
        checks++;
        if (almost_full !== a.af) begin
            failures++;
            $display("FAIL sb_almost_full: got %b expected %b", almost_full, a.af);
        end
`endif
    endtask

    task automatic check_cleared(input string tag);
        checks++;
        if ({graycode_wptr, write_address, full, overflow, write_en} !== 12'd0) begin
            failures++;
            $display("FAIL %s: gptr=%b addr=%0d full=%b ovf=%b we=%b expected all 0",
                     tag, graycode_wptr, write_address, full, overflow, write_en);
        end
`ifdef WRITE_INC_ALMOST_FULL_EN
        checks++;
        if (almost_full !== 1'b0) begin
            failures++;
            $display("FAIL %s_af: got %b expected 0", tag, almost_full);
        end
`endif
    endtask

    // Assert reset between edges, check asynchronous clear, release between edges.
    task automatic do_reset();
        rst = 1'b0;
        #2;
        check_cleared("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_cleared("held_reset");
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0; signal_write = 1'b1; graycode_rptr = 5'd0;
        model_reset();
        for (int t = 0; t < 5; t++) begin
            #20;
            check_cleared("reset_hold");
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b1, 5'd0);
        checks++;
        if (write_address !== 4'd1 || graycode_wptr !== 5'b00001) begin
            failures++;
            $display("FAIL first_write: addr=%0d gptr=%b expected 1 00001", write_address, graycode_wptr);
        end
    endtask

    task automatic test_fill();
        for (int k = 2; k <= 16; k++) begin
            cycle(1'b1, 5'd0);
`ifdef WRITE_INC_ALMOST_FULL_EN
            checks++;
            if (almost_full !== (k >= 12)) begin
                failures++;
                $display("FAIL af_edge%0d: got %b expected %b", k, almost_full, k >= 12);
            end
`endif
        end
        checks++;
        if (full !== 1'b1 || graycode_wptr !== 5'b11000 || write_address !== 4'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL fill16: full=%b gptr=%b addr=%0d ovf=%b expected 1 11000 0 0",
                     full, graycode_wptr, write_address, overflow);
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 5'd0);
            checks++;
            if (graycode_wptr !== 5'b11000 || overflow !== 1'b1) begin
                failures++;
                $display("FAIL write_while_full: gptr=%b ovf=%b expected 11000 1", graycode_wptr, overflow);
            end
        end
        cycle(1'b0, 5'd0);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: got %b expected 1", overflow);
        end
    endtask

    task automatic test_release();
        cycle(1'b0, 5'b00001);
        cycle(1'b0, 5'b00001);
        checks++;
        if (full !== 1'b1) begin
            failures++;
            $display("FAIL full_early_release: got %b expected 1", full);
        end
        cycle(1'b0, 5'b00001);
        checks++;
        if (full !== 1'b0) begin
            failures++;
            $display("FAIL full_release: got %b expected 0", full);
        end
        cycle(1'b1, 5'b00001);
        checks++;
        if (graycode_wptr !== 5'b11001 || full !== 1'b1) begin
            failures++;
            $display("FAIL refill: gptr=%b full=%b expected 11001 1", graycode_wptr, full);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] prev;
        int         bits;
        do_reset();
        prev = 5'd0;
        for (int k = 0; k < 32; k++) begin
            cycle(1'b1, b2g(m_wbin));
            bits = $countones(graycode_wptr ^ prev);
            checks++;
            if (bits != 1 || full !== 1'b0) begin
                failures++;
                $display("FAIL wrap_step%0d: changed_bits=%0d full=%b expected 1 0", k, bits, full);
            end
            prev = graycode_wptr;
        end
        checks++;
        if (graycode_wptr !== 5'b00000) begin
            failures++;
            $display("FAIL wrap_end: got %b expected 00000", graycode_wptr);
        end
    endtask

    task automatic test_midreset();
        for (int k = 0; k < 5; k++) cycle(1'b1, 5'd0);
        checks++;
        if (write_address !== 4'd5) begin
            failures++;
            $display("FAIL pre_midreset: addr=%0d expected 5", write_address);
        end
        do_reset();
        cycle(1'b1, 5'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_wrap();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
